// File: rtl/alu_seq_if.sv
// Request/response bundle between the command decoder and alu_seq.
// Ports: i_valid/i_oper/i_arg0/i_arg1 carry the request (master -> slave);
//        o_ready/o_valid/o_result/o_flag carry the response (slave -> master).
interface alu_seq_if #(
  parameter int WIDTH = 6
);
  logic             i_valid;
  logic [2:0]       i_oper;
  logic [WIDTH-1:0] i_arg0;
  logic [WIDTH-1:0] i_arg1;
  logic             o_ready;
  logic             o_valid;
  logic [WIDTH-1:0] o_result;
  logic [3:0]       o_flag;

  // Command decoder side.
  modport master (
    output i_valid, i_oper, i_arg0, i_arg1,
    input  o_ready, o_valid, o_result, o_flag
  );

  // ALU side.
  modport slave (
    input  i_valid, i_oper, i_arg0, i_arg1,
    output o_ready, o_valid, o_result, o_flag
  );
endinterface

// File: rtl/alu_seq.sv
// Purpose: registered signed ALU (ADD/SUB/AND/OR/XOR/MUL/ACC/ACLR) with NZVC flags.
// Latency: result valid 1 cycle after accept; MUL result valid WIDTH+1 cycles after accept.
// Backpressure: o_ready only in IDLE; i_valid seen while busy is dropped, never queued.
// Ports: i_clk, i_rst (sync, active-high), bus (alu_seq_if.slave: request + result/flags/done).
// Optional: define ALU_SAT_EN to clamp overflowing ADD/SUB/MUL/ACC results instead of wrapping.
module alu_seq #(
  parameter int WIDTH = 6
) (
  input  logic     i_clk,
  input  logic     i_rst,
  alu_seq_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

`ifdef ALU_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_MUL  = 3'd5;
  localparam logic [2:0] OP_ACC  = 3'd6;
  localparam logic [2:0] OP_ACLR = 3'd7;

  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [3:0]         flag_q, flag_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;   // |A|, shifted left one place per iteration
  logic [WIDTH-1:0]   mplier_q, mplier_d; // |B|, shifted right one place per iteration
  logic [2*WIDTH-1:0] prod_q, prod_d;     // unsigned partial product of magnitudes
  logic               sign_q, sign_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  function automatic logic [3:0] mk_flag(input logic [WIDTH-1:0] r, input logic v, input logic c);
    return {r[WIDTH-1], (r == '0), v, c};
  endfunction

  // ---------------- single-cycle datapath ----------------
  logic [WIDTH:0]   add_full, sub_full, acc_full;
  logic             add_v, sub_v, acc_v;
  logic [WIDTH-1:0] arg0_mag, arg1_mag;

  assign add_full = {1'b0, bus.i_arg0} + {1'b0, bus.i_arg1};
  assign sub_full = {1'b0, bus.i_arg0} + {1'b0, ~bus.i_arg1} + (WIDTH+1)'(1);
  assign acc_full = {1'b0, acc_q} + {1'b0, bus.i_arg0};

  // Signed overflow: operands (as seen by the adder) agree in sign, sum does not.
  assign add_v = (bus.i_arg0[WIDTH-1] == bus.i_arg1[WIDTH-1]) &&
                 (add_full[WIDTH-1] != bus.i_arg0[WIDTH-1]);
  assign sub_v = (bus.i_arg0[WIDTH-1] != bus.i_arg1[WIDTH-1]) &&
                 (sub_full[WIDTH-1] != bus.i_arg0[WIDTH-1]);
  assign acc_v = (acc_q[WIDTH-1] == bus.i_arg0[WIDTH-1]) &&
                 (acc_full[WIDTH-1] != acc_q[WIDTH-1]);

  // Magnitudes as unsigned WIDTH-bit values; -2^(W-1) maps to 2^(W-1), which still fits.
  assign arg0_mag = bus.i_arg0[WIDTH-1] ? (~bus.i_arg0 + WIDTH'(1)) : bus.i_arg0;
  assign arg1_mag = bus.i_arg1[WIDTH-1] ? (~bus.i_arg1 + WIDTH'(1)) : bus.i_arg1;

  logic [WIDTH-1:0] sop_res, sop_fin;
  logic             sop_v, sop_c, sop_neg;

  always_comb begin
    sop_res = '0;
    sop_v   = 1'b0;
    sop_c   = 1'b0;
    sop_neg = 1'b0;   // sign of the true (unwrapped) result, used only when clamping
    case (bus.i_oper)
      OP_ADD: begin
        sop_res = add_full[WIDTH-1:0];
        sop_v   = add_v;
        sop_c   = add_full[WIDTH];
        sop_neg = bus.i_arg0[WIDTH-1];
      end
      OP_SUB: begin
        sop_res = sub_full[WIDTH-1:0];
        sop_v   = sub_v;
        sop_c   = sub_full[WIDTH];
        sop_neg = bus.i_arg0[WIDTH-1];
      end
      OP_AND: sop_res = bus.i_arg0 & bus.i_arg1;
      OP_OR:  sop_res = bus.i_arg0 | bus.i_arg1;
      OP_XOR: sop_res = bus.i_arg0 ^ bus.i_arg1;
      OP_ACC: begin
        sop_res = acc_full[WIDTH-1:0];
        sop_v   = acc_v;
        sop_c   = acc_full[WIDTH];
        sop_neg = acc_q[WIDTH-1];
      end
      default: sop_res = '0;   // ACLR; MUL takes the iterative path
    endcase
    sop_fin = (SAT_EN && sop_v) ? (sop_neg ? SAT_MIN : SAT_MAX) : sop_res;
  end

  // ---------------- iterative multiply datapath ----------------
  logic [2*WIDTH-1:0] mul_sum, mul_sgn;
  logic               mul_v;
  logic [WIDTH-1:0]   mul_fin;

  always_comb begin
    mul_sum = prod_q + (mplier_q[0] ? mcand_q : '0);
    mul_sgn = sign_q ? (~mul_sum + (2*WIDTH)'(1)) : mul_sum;
    // Fits in WIDTH signed bits iff the top WIDTH+1 bits are all copies of the sign.
    mul_v   = !((&mul_sgn[2*WIDTH-1:WIDTH-1]) || !(|mul_sgn[2*WIDTH-1:WIDTH-1]));
    mul_fin = (SAT_EN && mul_v) ? (sign_q ? SAT_MIN : SAT_MAX) : mul_sgn[WIDTH-1:0];
  end

  // ---------------- FSM next state / register updates ----------------
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flag_d   = flag_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    sign_d   = sign_q;
    cnt_d    = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (bus.i_valid) begin
          if (bus.i_oper == OP_MUL) begin
            mcand_d  = {{WIDTH{1'b0}}, arg0_mag};
            mplier_d = arg1_mag;
            prod_d   = '0;
            sign_d   = bus.i_arg0[WIDTH-1] ^ bus.i_arg1[WIDTH-1];
            cnt_d    = '0;
            state_d  = S_MUL;
          end else begin
            result_d = sop_fin;
            flag_d   = mk_flag(sop_fin, sop_v, sop_c);
            if (bus.i_oper == OP_ACC)  acc_d = sop_fin;
            if (bus.i_oper == OP_ACLR) acc_d = '0;
            state_d  = S_DONE;
          end
        end
      end

      S_MUL: begin
        prod_d   = mul_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        // The last iteration's sum is finished combinationally and registered directly.
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          result_d = mul_fin;
          flag_d   = mk_flag(mul_fin, mul_v, 1'b0);
          state_d  = S_DONE;
        end
      end

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      flag_q   <= 4'b0000;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      sign_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flag_q   <= flag_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      sign_q   <= sign_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.o_ready  = (state_q == S_IDLE);
  assign bus.o_valid  = (state_q == S_DONE);
  assign bus.o_result = result_q;
  assign bus.o_flag   = flag_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq at WIDTH=6: directed vector table, hand-written multi-cycle
// sequences (busy-ignore, reset mid-multiply) and randomized ops vs. an integer model.
module tb_alu_seq;

`ifdef ALU_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;
  int   macc;   // model accumulator, plain signed integer

  alu_seq_if #(.WIDTH(6)) bus ();

  alu_seq #(.WIDTH(6)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    int         a;
    int         b;
    int         wres;
    logic [3:0] wflg;
    int         sres;
    logic [3:0] sflg;
    int         lat;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t mk(input logic [2:0] op, input int a, input int b,
                              input int wres, input logic [3:0] wflg,
                              input int sres, input logic [3:0] sflg, input int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.wres = wres; v.wflg = wflg;
    v.sres = sres; v.sflg = sflg; v.lat = lat;
    return v;
  endfunction

  function automatic int sx(input logic [5:0] v);
    return v[5] ? int'(v) - 64 : int'(v);
  endfunction

  task automatic check(input string name, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  // Reference model: true mathematical result, then wrap or clamp to 6 bits.
  task automatic model(input logic [2:0] op, input int a, input int b,
                       output int res, output logic [3:0] flg);
    int t;
    bit v, c, arith;
    int ua, ub;
    logic [5:0] r6;
    ua = a & 63;
    ub = b & 63;
    c = 0;
    arith = 1;
    case (op)
      3'd0: begin t = a + b;    c = (ua + ub) > 63; end
      3'd1: begin t = a - b;    c = (ua >= ub);     end
      3'd2: begin t = a & b;    arith = 0;          end
      3'd3: begin t = a | b;    arith = 0;          end
      3'd4: begin t = a ^ b;    arith = 0;          end
      3'd5: begin t = a * b;                        end
      3'd6: begin t = macc + a; c = ((macc & 63) + ua) > 63; end
      default: begin t = 0;     arith = 0;          end
    endcase
    v = arith && (t > 31 || t < -32);
    if (SAT && v) t = (t > 0) ? 31 : -32;
    r6 = t[5:0];
    res = sx(r6);
    flg = {r6[5], (r6 == 6'd0), v, c};
    if (op == 3'd6) macc = res;
    if (op == 3'd7) macc = 0;
  endtask

  // Issue one op from a negedge; returns at the negedge after the DONE cycle.
  // lat = samples from accept until o_valid seen (1 = cycle right after accept).
  task automatic run_op(input logic [2:0] op, input int a, input int b,
                        output int res, output logic [3:0] flg,
                        output int lat, output int rdy_low);
    int w;
    w = 0;
    while (!bus.o_ready && w < 20) begin @(negedge clk); w++; end
    bus.i_valid = 1'b1;
    bus.i_oper  = op;
    bus.i_arg0  = a[5:0];
    bus.i_arg1  = b[5:0];
    @(posedge clk);
    @(negedge clk);
    bus.i_valid = 1'b0;
    // Operands must not matter after accept.
    bus.i_oper  = 3'($urandom);
    bus.i_arg0  = 6'($urandom);
    bus.i_arg1  = 6'($urandom);
    lat = 1;
    rdy_low = 0;
    while (!bus.o_valid && lat < 40) begin
      if (!bus.o_ready) rdy_low++;
      @(negedge clk);
      lat++;
    end
    if (!bus.o_ready) rdy_low++;
    res = sx(bus.o_result);
    flg = bus.o_flag;
    @(negedge clk);
  endtask

  initial begin
    int res, lat, rl, eres, pulses;
    logic [3:0] flg, eflg;

    n_chk = 0;
    n_pass = 0;
    macc = 0;
    rst = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_oper  = 3'd0;
    bus.i_arg0  = 6'd0;
    bus.i_arg1  = 6'd0;

    tbl[0]  = mk(3'd0,   2, 13,  15, 4'b0000,  15, 4'b0000, 1);
    tbl[1]  = mk(3'd0,  17, 18, -29, 4'b1010,  31, 4'b0010, 1);
    tbl[2]  = mk(3'd1,   1,  1,   0, 4'b0101,   0, 4'b0101, 1);
    tbl[3]  = mk(3'd2,   5,  2,   0, 4'b0100,   0, 4'b0100, 1);
    tbl[4]  = mk(3'd5,   5,  2,  10, 4'b0000,  10, 4'b0000, 7);
    tbl[5]  = mk(3'd5,  -3,  4, -12, 4'b1000, -12, 4'b1000, 7);
    tbl[6]  = mk(3'd5,   8,  8,   0, 4'b0110,  31, 4'b0010, 7);
    tbl[7]  = mk(3'd3, -32,  1, -31, 4'b1000, -31, 4'b1000, 1);
    tbl[8]  = mk(3'd4,  21, 21,   0, 4'b0100,   0, 4'b0100, 1);
    tbl[9]  = mk(3'd1, -32,  1,  31, 4'b0011, -32, 4'b1011, 1);
    tbl[10] = mk(3'd0,  -1,  1,   0, 4'b0101,   0, 4'b0101, 1);
    tbl[11] = mk(3'd5, -32, -1, -32, 4'b1010,  31, 4'b0010, 7);
    tbl[12] = mk(3'd5, -32,  1, -32, 4'b1000, -32, 4'b1000, 7);
    tbl[13] = mk(3'd1,   3,  5,  -2, 4'b1000,  -2, 4'b1000, 1);
    tbl[14] = mk(3'd7,   0,  0,   0, 4'b0100,   0, 4'b0100, 1);
    tbl[15] = mk(3'd6,  20,  0,  20, 4'b0000,  20, 4'b0000, 1);
    tbl[16] = mk(3'd6,  20,  0, -24, 4'b1010,  31, 4'b0010, 1);
    tbl[17] = mk(3'd7,   0,  0,   0, 4'b0100,   0, 4'b0100, 1);

    // ---- reset state ----
    repeat (2) @(negedge clk);
    check("rst_ready",  int'(bus.o_ready), 1);
    check("rst_valid",  int'(bus.o_valid), 0);
    check("rst_result", int'(bus.o_result), 0);
    check("rst_flag",   int'(bus.o_flag), 0);
    rst = 1'b0;
    @(negedge clk);

    // ---- directed table ----
    for (int i = 0; i < 18; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, res, flg, lat, rl);
      check($sformatf("tbl%0d_res", i), res, SAT ? tbl[i].sres : tbl[i].wres);
      check($sformatf("tbl%0d_flag", i), int'(flg), int'(SAT ? tbl[i].sflg : tbl[i].wflg));
      check($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
      check($sformatf("tbl%0d_rdylow", i), rl, tbl[i].lat);
      check($sformatf("tbl%0d_vld_pulse", i), int'(bus.o_valid), 0);
    end
    macc = 0;

    // ---- ADD pulsed while MUL busy must be dropped ----
    bus.i_valid = 1'b1; bus.i_oper = 3'd5; bus.i_arg0 = 6'd5; bus.i_arg1 = 6'd2;
    @(posedge clk); @(negedge clk);
    bus.i_valid = 1'b0;
    @(negedge clk);
    bus.i_valid = 1'b1; bus.i_oper = 3'd0; bus.i_arg0 = 6'd1; bus.i_arg1 = 6'd1;
    @(negedge clk);
    bus.i_valid = 1'b0;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.o_valid) begin
        pulses++;
        check("busy_mul_res", sx(bus.o_result), 10);
        check("busy_mul_flag", int'(bus.o_flag), 0);
      end
      @(negedge clk);
    end
    check("busy_pulses", pulses, 1);

    // ---- reset three cycles into MUL aborts and clears acc ----
    model(3'd6, 5, 0, eres, eflg);
    run_op(3'd6, 5, 0, res, flg, lat, rl);
    check("pre_rst_acc", res, eres);
    bus.i_valid = 1'b1; bus.i_oper = 3'd5; bus.i_arg0 = 6'd7; bus.i_arg1 = 6'd3;
    @(posedge clk); @(negedge clk);
    bus.i_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_ready",  int'(bus.o_ready), 1);
    check("abort_valid",  int'(bus.o_valid), 0);
    check("abort_result", int'(bus.o_result), 0);
    check("abort_flag",   int'(bus.o_flag), 0);
    rst = 1'b0;
    macc = 0;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      if (bus.o_valid) pulses++;
      @(negedge clk);
    end
    check("abort_no_pulse", pulses, 0);
    model(3'd6, 1, 0, eres, eflg);
    run_op(3'd6, 1, 0, res, flg, lat, rl);
    check("post_rst_acc_res", res, eres);
    check("post_rst_acc_flag", int'(flg), int'(eflg));

    // ---- randomized ops vs. model ----
    for (int i = 0; i < 150; i++) begin
      logic [2:0] op;
      int a, b;
      op = 3'($urandom_range(0, 7));
      a = int'($urandom_range(0, 63)) - 32;
      b = int'($urandom_range(0, 63)) - 32;
      model(op, a, b, eres, eflg);
      run_op(op, a, b, res, flg, lat, rl);
      check($sformatf("rnd%0d_op%0d_res", i, op), res, eres);
      check($sformatf("rnd%0d_op%0d_flag", i, op), int'(flg), int'(eflg));
      check($sformatf("rnd%0d_op%0d_lat", i, op), lat, (op == 3'd5) ? 7 : 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
